// File: rtl/rtc_bcd_clock.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bcd_clock
// Purpose  : BCD real-time clock core. A built-in prescaler derives a
//            one-second tick from CLK. Time is kept internally as 24-hour BCD
//            digits. The core supports a runtime 12/24-hour display, a
//            validated load handshake, a one-shot alarm and a midnight pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV  CLK cycles per one-second tick (>= 1)
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   EN         in   count enable (prescaler and time frozen when low)
//   MODE12     in   1 = 12-hour display, 0 = 24-hour display
//   SET_VLD    in   load request, sampled every cycle
//   SET_TIME   in   [23:0] BCD load value {HRM,HRL,MIN_M,MIN_L,SEC_M,SEC_L}
//   SET_ACK    out  one-cycle pulse, load accepted
//   SET_ERR    out  one-cycle pulse, load rejected
//   ALM_EN     in   alarm enable
//   ALM_TIME   in   [23:0] BCD alarm time, 24-hour format
//   HRM..SEC_L out  [3:0] displayed BCD digits
//   PM         out  internal hour is 12..23
//   TICK       out  one-cycle pulse per one-second advance
//   ALARM      out  one-cycle pulse on alarm match
//   MIDNIGHT   out  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
// ============================================================================
module rtc_bcd_clock #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        MODE12,
  input  logic        SET_VLD,
  input  logic [23:0] SET_TIME,
  output logic        SET_ACK,
  output logic        SET_ERR,
  input  logic        ALM_EN,
  input  logic [23:0] ALM_TIME,
  output logic [3:0]  HRM,
  output logic [3:0]  HRL,
  output logic [3:0]  MIN_M,
  output logic [3:0]  MIN_L,
  output logic [3:0]  SEC_M,
  output logic [3:0]  SEC_L,
  output logic        PM,
  output logic        TICK,
  output logic        ALARM,
  output logic        MIDNIGHT
);

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] presc_q,  presc_d;
  logic [3:0]    hrm_q,    hrm_d;
  logic [3:0]    hrl_q,    hrl_d;
  logic [3:0]    minm_q,   minm_d;
  logic [3:0]    minl_q,   minl_d;
  logic [3:0]    secm_q,   secm_d;
  logic [3:0]    secl_q,   secl_d;
  logic          tick_q,   tick_d;
  logic          alarm_q,  alarm_d;
  logic          mid_q,    mid_d;
  logic          ack_q,    ack_d;
  logic          err_q,    err_d;

  // --------------------------------------------------------------------------
  // One-second advance: all carries resolve combinationally so that the
  // registered time never passes through an out-of-range value.
  // --------------------------------------------------------------------------
  logic       tick_w;
  logic       secl_wrap_w, secm_wrap_w, minl_wrap_w, minm_wrap_w, hr23_w;
  logic [3:0] inc_hrm_w, inc_hrl_w, inc_minm_w, inc_minl_w, inc_secm_w, inc_secl_w;
  logic       inc_mid_w;

  always_comb begin
    tick_w      = EN && (presc_q == PRESC_MAX);

    secl_wrap_w = (secl_q == 4'd9);
    secm_wrap_w = secl_wrap_w && (secm_q == 4'd5);
    minl_wrap_w = secm_wrap_w && (minl_q == 4'd9);
    minm_wrap_w = minl_wrap_w && (minm_q == 4'd5);
    hr23_w      = (hrm_q == 4'd2) && (hrl_q == 4'd3);

    inc_secl_w  = secl_wrap_w ? 4'd0 : secl_q + 4'd1;
    inc_secm_w  = secl_wrap_w ? (secm_wrap_w ? 4'd0 : secm_q + 4'd1) : secm_q;
    inc_minl_w  = secm_wrap_w ? (minl_wrap_w ? 4'd0 : minl_q + 4'd1) : minl_q;
    inc_minm_w  = minl_wrap_w ? (minm_wrap_w ? 4'd0 : minm_q + 4'd1) : minm_q;

    inc_hrm_w   = hrm_q;
    inc_hrl_w   = hrl_q;
    if (minm_wrap_w) begin
      if (hr23_w) begin
        inc_hrm_w = 4'd0;
        inc_hrl_w = 4'd0;
      end else if (hrl_q == 4'd9) begin
        inc_hrm_w = hrm_q + 4'd1;
        inc_hrl_w = 4'd0;
      end else begin
        inc_hrl_w = hrl_q + 4'd1;
      end
    end

    inc_mid_w   = minm_wrap_w && hr23_w;
  end

  // --------------------------------------------------------------------------
  // Load validation. Checking HRM <= 2 alone is not enough: 24..29 must be
  // rejected as well, so the hour's units digit is constrained when HRM = 2.
  // --------------------------------------------------------------------------
  logic set_ok_w;

  always_comb begin
    set_ok_w = (SET_TIME[23:20] <= 4'd2) &&
               (SET_TIME[19:16] <= 4'd9) &&
               !((SET_TIME[23:20] == 4'd2) && (SET_TIME[19:16] > 4'd3)) &&
               (SET_TIME[15:12] <= 4'd5) &&
               (SET_TIME[11:8]  <= 4'd9) &&
               (SET_TIME[7:4]   <= 4'd5) &&
               (SET_TIME[3:0]   <= 4'd9);
  end

  // --------------------------------------------------------------------------
  // Next state. A load (valid or not) pre-empts a coincident tick; a rejected
  // load therefore also holds the prescaler for that cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    hrm_d   = hrm_q;
    hrl_d   = hrl_q;
    minm_d  = minm_q;
    minl_d  = minl_q;
    secm_d  = secm_q;
    secl_d  = secl_q;
    tick_d  = 1'b0;
    alarm_d = 1'b0;
    mid_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    if (SET_VLD) begin
      if (set_ok_w) begin
        {hrm_d, hrl_d, minm_d, minl_d, secm_d, secl_d} = SET_TIME;
        presc_d = '0;
        ack_d   = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end else if (tick_w) begin
      presc_d = '0;
      hrm_d   = inc_hrm_w;
      hrl_d   = inc_hrl_w;
      minm_d  = inc_minm_w;
      minl_d  = inc_minl_w;
      secm_d  = inc_secm_w;
      secl_d  = inc_secl_w;
      tick_d  = 1'b1;
      mid_d   = inc_mid_w;
      // Match against the value being entered, so the pulse lines up with TICK.
      alarm_d = ALM_EN &&
                ({inc_hrm_w, inc_hrl_w, inc_minm_w, inc_minl_w,
                  inc_secm_w, inc_secl_w} == ALM_TIME);
    end else if (EN) begin
      presc_d = presc_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      hrm_q   <= 4'd0;
      hrl_q   <= 4'd0;
      minm_q  <= 4'd0;
      minl_q  <= 4'd0;
      secm_q  <= 4'd0;
      secl_q  <= 4'd0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      mid_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hrm_q   <= hrm_d;
      hrl_q   <= hrl_d;
      minm_q  <= minm_d;
      minl_q  <= minl_d;
      secm_q  <= secm_d;
      secl_q  <= secl_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
      mid_q   <= mid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Display mapping. In 12-hour mode: 00 -> 12, 01..12 unchanged,
  // 13..19 -> 01..07 (units minus 2), 20..21 -> 08..09 (units plus 8),
  // 22..23 -> 10..11 (units minus 2).
  // --------------------------------------------------------------------------
  logic [3:0] disp_hrm_w, disp_hrl_w;

  always_comb begin
    disp_hrm_w = hrm_q;
    disp_hrl_w = hrl_q;
    if (MODE12) begin
      if ((hrm_q == 4'd0) && (hrl_q == 4'd0)) begin
        disp_hrm_w = 4'd1;
        disp_hrl_w = 4'd2;
      end else if ((hrm_q == 4'd1) && (hrl_q >= 4'd3)) begin
        disp_hrm_w = 4'd0;
        disp_hrl_w = hrl_q - 4'd2;
      end else if (hrm_q == 4'd2) begin
        if (hrl_q < 4'd2) begin
          disp_hrm_w = 4'd0;
          disp_hrl_w = hrl_q + 4'd8;
        end else begin
          disp_hrm_w = 4'd1;
          disp_hrl_w = hrl_q - 4'd2;
        end
      end
    end
  end

  assign HRM      = disp_hrm_w;
  assign HRL      = disp_hrl_w;
  assign MIN_M    = minm_q;
  assign MIN_L    = minl_q;
  assign SEC_M    = secm_q;
  assign SEC_L    = secl_q;
  assign PM       = (hrm_q == 4'd2) || ((hrm_q == 4'd1) && (hrl_q >= 4'd2));
  assign TICK     = tick_q;
  assign ALARM    = alarm_q;
  assign MIDNIGHT = mid_q;
  assign SET_ACK  = ack_q;
  assign SET_ERR  = err_q;

endmodule
`default_nettype wire
